// File: rtl/global_memory.sv
// ---------------------------------------------------------------------------
// global_memory
//
// Byte-addressable, big-endian data memory for the MIPS pipeline, plus the
// print-string engine used by the W-stage syscall (v0 = 4). The engine walks
// a NUL-terminated string from a0 and emits one character per cycle.
//
// Ports:
//   clk         system clock, all state changes on posedge
//   reset       synchronous active-high reset (aborts printing, blocks stores)
//   str_cntrl   print request level; a rising edge starts a print when idle
//   str_addr    string start address (a0)
//   mem_read    load enable; read_data is 0 when low
//   mem_write   store enable
//   mem_byte    1 = byte access, 0 = word access
//   addr        load/store address (wraps modulo MEM_BYTES)
//   write_data  store data; byte stores use [7:0]
//   read_data   combinational load data
//   char_valid  registered, char_out holds a character this cycle
//   char_out    registered character (holds its last value when not valid)
//   str_busy    print engine active
//   str_done    one-cycle pulse when a string finishes
//
// Handshake: char_valid is a pure qualifier with no back-pressure; a
// character is delivered on every cycle char_valid is high, exactly once.
// ---------------------------------------------------------------------------
module global_memory #(
    parameter int MEM_BYTES = 4096,
    parameter int ADDR_BITS = 12,
    parameter int MAX_STR   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        str_cntrl,
    input  logic [31:0] str_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_byte,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        char_valid,
    output logic [7:0]  char_out,
    output logic        str_busy,
    output logic        str_done
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int CNT_W = $clog2(MAX_STR + 1);

    // Memory contents start at zero and are deliberately untouched by reset.
    logic [7:0] mem_q [MEM_BYTES] = '{default: 8'h00};

    state_t                 state_q, state_d;
    logic                   prev_str_q, prev_str_d;
    logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   char_valid_q, char_valid_d;
    logic [7:0]             char_out_q, char_out_d;
    logic                   str_done_q, str_done_d;

    logic [ADDR_BITS-1:0]   idx;
    logic [ADDR_BITS-1:0]   w0, w1, w2, w3;
    logic [7:0]             cur_byte;
    logic                   start;

    // Only the low address bits select a byte; the rest is ignored.
    logic unused_bits;
    assign unused_bits = ^{addr[31:ADDR_BITS], str_addr[31:ADDR_BITS]};

    // Word accesses are force-aligned: addr[1:0] is replaced per byte lane.
    assign idx = addr[ADDR_BITS-1:0];
    assign w0  = {idx[ADDR_BITS-1:2], 2'b00};
    assign w1  = {idx[ADDR_BITS-1:2], 2'b01};
    assign w2  = {idx[ADDR_BITS-1:2], 2'b10};
    assign w3  = {idx[ADDR_BITS-1:2], 2'b11};

    // Loads
    always_comb begin
        read_data = 32'h0;
        if (mem_read) begin
            if (mem_byte) begin
                read_data = {24'h0, mem_q[idx]};
            end else begin
                read_data = {mem_q[w0], mem_q[w1], mem_q[w2], mem_q[w3]};
            end
        end
    end

    // Stores (big-endian for words)
    always_ff @(posedge clk) begin
        if (!reset && mem_write) begin
            if (mem_byte) begin
                mem_q[idx] <= write_data[7:0];
            end else begin
                mem_q[w0] <= write_data[31:24];
                mem_q[w1] <= write_data[23:16];
                mem_q[w2] <= write_data[15:8];
                mem_q[w3] <= write_data[7:0];
            end
        end
    end

    // The engine samples the array before this edge's store lands, so a
    // store to the current pointer is seen on the following cycle.
    assign cur_byte = mem_q[ptr_q];
    assign start    = str_cntrl && !prev_str_q && (state_q == IDLE);

    always_comb begin
        state_d      = state_q;
        prev_str_d   = str_cntrl;
        ptr_d        = ptr_q;
        count_d      = count_q;
        char_valid_d = 1'b0;
        char_out_d   = char_out_q;
        str_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d   = str_addr[ADDR_BITS-1:0];
                    count_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cur_byte != 8'h00 && count_q < CNT_W'(MAX_STR)) begin
                    char_valid_d = 1'b1;
                    char_out_d   = cur_byte;
                    ptr_d        = ptr_q + ADDR_BITS'(1);
                    count_d      = count_q + CNT_W'(1);
                end else begin
                    str_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            prev_str_q   <= 1'b0;
            ptr_q        <= '0;
            count_q      <= '0;
            char_valid_q <= 1'b0;
            char_out_q   <= 8'h00;
            str_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_str_q   <= prev_str_d;
            ptr_q        <= ptr_d;
            count_q      <= count_d;
            char_valid_q <= char_valid_d;
            char_out_q   <= char_out_d;
            str_done_q   <= str_done_d;
        end
    end

`ifndef SYNTHESIS
    // Console echo of each emitted character.
    always_ff @(posedge clk) begin
        if (!reset && char_valid_d) begin
            $write("%c", cur_byte);
        end
    end
`endif

    assign char_valid = char_valid_q;
    assign char_out   = char_out_q;
    assign str_busy   = (state_q == BUSY);
    assign str_done   = str_done_q;

endmodule

// File: tb/tb_global_memory.sv
// ---------------------------------------------------------------------------
// tb_global_memory
//
// Directed bench for global_memory. Characters expected from the print
// engine are pushed to exp_q when a print is requested; a monitor pops and
// compares them whenever char_valid is seen.
// ---------------------------------------------------------------------------
module tb_global_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic        str_cntrl;
    logic [31:0] str_addr;
    logic        mem_read;
    logic        mem_write;
    logic        mem_byte;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        char_valid;
    logic [7:0]  char_out;
    logic        str_busy;
    logic        str_done;

    int checks = 0;
    int errors = 0;
    int n_chars = 0;
    int n_done = 0;

    logic [7:0] exp_q[$];

    global_memory dut (
        .clk        (clk),
        .reset      (reset),
        .str_cntrl  (str_cntrl),
        .str_addr   (str_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_byte   (mem_byte),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .char_valid (char_valid),
        .char_out   (char_out),
        .str_busy   (str_busy),
        .str_done   (str_done)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor / scoreboard: samples 1 time unit after each rising edge.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (char_valid === 1'b1) begin
                n_chars++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_char: observed %h expected none", char_out);
                end else begin
                    e = exp_q.pop_front();
                    check("char_out", {24'h0, char_out}, {24'h0, e});
                end
            end
            if (str_done === 1'b1) n_done++;
        end
    end

    // Driver tasks
    task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_write = 1'b1; mem_byte = 1'b0; addr = a; write_data = d;
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    task automatic wr_byte(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        mem_write = 1'b1; mem_byte = 1'b1; addr = a; write_data = {24'h0, d};
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic b,
                            input logic [31:0] exp);
        @(negedge clk);
        mem_read = 1'b1; mem_byte = b; addr = a;
        #1;
        check(tag, read_data, exp);
        mem_read = 1'b0;
    endtask

    task automatic store_str(input logic [31:0] base, input string s);
        for (int i = 0; i < s.len(); i++) wr_byte(base + 32'(i), s[i]);
        wr_byte(base + 32'(s.len()), 8'h00);
    endtask

    // Request a print of s from base, wait (bounded) for str_done.
    task automatic print_str(input string tag, input logic [31:0] base, input string s,
                             input int bound);
        logic seen;
        int c0;
        seen = 1'b0;
        c0 = n_chars;
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        @(negedge clk);
        str_addr = base; str_cntrl = 1'b1;
        for (int cyc = 0; cyc < bound; cyc++) begin
            @(posedge clk);
            #1;
            if (str_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, {31'h0, seen}, 32'h1);
        check({tag, "_nchars"}, 32'(n_chars - c0), 32'(s.len()));
        @(negedge clk);
        str_cntrl = 1'b0;
    endtask

    initial begin
        int d0, c0, valid_cnt;
        logic seen;
        logic [7:0] b;

        reset = 1'b1; str_cntrl = 1'b0; str_addr = 32'h0; mem_read = 1'b0;
        mem_write = 1'b0; mem_byte = 1'b0; addr = 32'h0; write_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_char_valid", {31'h0, char_valid}, 32'h0);
        check("rst_char_out", {24'h0, char_out}, 32'h0);
        check("rst_str_busy", {31'h0, str_busy}, 32'h0);
        check("rst_str_done", {31'h0, str_done}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // read_data is 0 when mem_read is low
        wr_word(32'h100, 32'hDEADBEEF);
        @(negedge clk);
        addr = 32'h100; mem_read = 1'b0;
        #1;
        check("rd_disabled", read_data, 32'h0);

        // Big-endian word and byte loads
        rd_check("word_100", 32'h100, 1'b0, 32'hDEADBEEF);
        rd_check("byte_100", 32'h100, 1'b1, 32'h000000DE);
        rd_check("byte_101", 32'h101, 1'b1, 32'h000000AD);
        rd_check("byte_102", 32'h102, 1'b1, 32'h000000BE);
        rd_check("byte_103", 32'h103, 1'b1, 32'h000000EF);

        // Byte store, alignment, wrap
        wr_word(32'h204, 32'h0);
        wr_byte(32'h205, 8'h41);
        rd_check("word_204", 32'h204, 1'b0, 32'h00410000);
        rd_check("word_206_align", 32'h206, 1'b0, 32'h00410000);
        rd_check("word_1204_wrap", 32'h1204, 1'b0, 32'h00410000);
        rd_check("byte_1205_wrap", 32'h1205, 1'b1, 32'h00000041);
        wr_byte(32'h1207, 8'h5A);
        rd_check("word_204_alias_wr", 32'h204, 1'b0, 32'h0041005A);
        wr_word(32'h20B, 32'h11223344);
        rd_check("word_208_unaligned_wr", 32'h208, 1'b0, 32'h11223344);

        // Stores are suppressed during reset
        wr_word(32'h400, 32'hCAFEF00D);
        @(negedge clk);
        reset = 1'b1; mem_write = 1'b1; mem_byte = 1'b0; addr = 32'h400; write_data = 32'h12345678;
        @(negedge clk);
        mem_write = 1'b0; reset = 1'b0;
        rd_check("store_in_reset", 32'h400, 1'b0, 32'hCAFEF00D);

        // "Hi" with exact cycle-level latency
        store_str(32'h300, "Hi");
        d0 = n_done;
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h69);
        @(negedge clk);
        str_addr = 32'h300; str_cntrl = 1'b1;
        @(posedge clk); #1;   // edge E
        check("hi_E_busy", {31'h0, str_busy}, 32'h1);
        check("hi_E_valid", {31'h0, char_valid}, 32'h0);
        @(posedge clk); #1;   // E+1
        check("hi_E1_valid", {31'h0, char_valid}, 32'h1);
        check("hi_E1_char", {24'h0, char_out}, 32'h48);
        @(posedge clk); #1;   // E+2
        check("hi_E2_valid", {31'h0, char_valid}, 32'h1);
        check("hi_E2_char", {24'h0, char_out}, 32'h69);
        @(posedge clk); #1;   // E+3
        check("hi_E3_done", {31'h0, str_done}, 32'h1);
        check("hi_E3_busy", {31'h0, str_busy}, 32'h0);
        check("hi_E3_valid", {31'h0, char_valid}, 32'h0);
        check("hi_E3_char_hold", {24'h0, char_out}, 32'h69);
        @(posedge clk); #1;   // E+4
        check("hi_E4_done_pulse", {31'h0, str_done}, 32'h0);

        // Held-high level must not retrigger
        c0 = n_chars;
        repeat (10) begin
            @(posedge clk); #1;
            check("hold_no_busy", {31'h0, str_busy}, 32'h0);
        end
        check("hold_no_chars", 32'(n_chars - c0), 32'h0);
        check("hold_done_count", 32'(n_done - d0), 32'h1);
        @(negedge clk);
        str_cntrl = 1'b0;
        print_str("hi_again", 32'h300, "Hi", 20);

        // Reset after the first character aborts with no str_done
        store_str(32'h320, "Hello");
        d0 = n_done;
        exp_q.push_back(8'h48);
        @(negedge clk);
        str_addr = 32'h320; str_cntrl = 1'b1;
        @(posedge clk); #1;   // E
        @(posedge clk); #1;   // E+1
        check("abort_first_char", {24'h0, char_out}, 32'h48);
        @(negedge clk);
        reset = 1'b1; str_cntrl = 1'b0;
        @(posedge clk); #1;
        check("abort_valid", {31'h0, char_valid}, 32'h0);
        check("abort_busy", {31'h0, str_busy}, 32'h0);
        check("abort_done", {31'h0, str_done}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        c0 = n_chars;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_more_chars", 32'(n_chars - c0), 32'h0);
        check("abort_no_done", 32'(n_done - d0), 32'h0);
        print_str("hello_full", 32'h320, "Hello", 20);

        // Unterminated string, starting near the top so the pointer wraps
        for (int i = 0; i < 1030; i++) begin
            b = (i % 64 == 63) ? 8'h0A : 8'(8'h61 + (i % 26));
            wr_byte(32'hE00 + 32'(i), b);
            if (i < 1024) exp_q.push_back(b);
        end
        d0 = n_done;
        valid_cnt = 0;
        seen = 1'b0;
        @(negedge clk);
        str_addr = 32'hE00; str_cntrl = 1'b1;
        for (int cyc = 0; cyc < 1100; cyc++) begin
            @(posedge clk); #1;
            if (char_valid === 1'b1) valid_cnt++;
            if (str_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("max_done", {31'h0, seen}, 32'h1);
        check("max_valid_cycles", 32'(valid_cnt), 32'd1024);
        check("max_done_count", 32'(n_done - d0), 32'h1);
        @(negedge clk);
        str_cntrl = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_empty", 32'(exp_q.size()), 32'h0);

        $display("");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
